// File: rtl/ser_frame_tx.sv
// Serial frame transmitter: START, 2 address bits, 4 length bits, L payload bits, optional parity, STOP.
// Define SER_FRAME_TX_PARITY_EN to insert an even-parity bit ahead of STOP.
module ser_frame_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        clkEn,
    input  logic        start,
    input  logic [1:0]  port_addr,
    input  logic [3:0]  data_len,
    input  logic [14:0] data_in,
    output logic        serOut,
    output logic        busy,
    output logic        Done,
    output logic [2:0]  state_dbg_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ADDR  = 3'd2,
        S_LEN   = 3'd3,
        S_DATA  = 3'd4,
`ifdef SER_FRAME_TX_PARITY_EN
        S_PAR   = 3'd5,
`endif
        S_STOP  = 3'd6
    } state_t;

`ifdef SER_FRAME_TX_PARITY_EN
    localparam state_t S_AFTER_BODY = S_PAR;
`else
    localparam state_t S_AFTER_BODY = S_STOP;
`endif

    state_t      state_q, state_d;
    logic [1:0]  addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    // Bit 15 is a constant zero pad so the 4-bit DATA index never leaves the vector.
    logic [15:0] data_q, data_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [3:0]  dcnt_q, dcnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 2'd0;
            len_q   <= 4'd0;
            data_q  <= 16'd0;
            bcnt_q  <= 2'd0;
            dcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            data_q  <= data_d;
            bcnt_q  <= bcnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        data_d  = data_q;
        bcnt_d  = bcnt_q;
        dcnt_d  = dcnt_q;
        if (clkEn) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_d  = port_addr;
                        len_d   = data_len;
                        data_d  = {1'b0, data_in};
                        state_d = S_START;
                    end
                end
                S_START: begin
                    bcnt_d  = 2'd1;
                    state_d = S_ADDR;
                end
                S_ADDR: begin
                    if (bcnt_q == 2'd0) begin
                        bcnt_d  = 2'd3;
                        state_d = S_LEN;
                    end else begin
                        bcnt_d = bcnt_q - 2'd1;
                    end
                end
                S_LEN: begin
                    if (bcnt_q != 2'd0) begin
                        bcnt_d = bcnt_q - 2'd1;
                    end else if (len_q == 4'd0) begin
                        state_d = S_AFTER_BODY;
                    end else begin
                        dcnt_d  = len_q - 4'd1;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (dcnt_q == 4'd0) begin
                        state_d = S_AFTER_BODY;
                    end else begin
                        dcnt_d = dcnt_q - 4'd1;
                    end
                end
`ifdef SER_FRAME_TX_PARITY_EN
                S_PAR: state_d = S_STOP;
`endif
                S_STOP: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef SER_FRAME_TX_PARITY_EN
    logic parity;
    // Only the L transmitted payload bits take part in the parity.
    assign parity = (^addr_q) ^ (^len_q) ^ (^(data_q & ~(16'hFFFF << len_q)));
`endif

    always_comb begin
        serOut = 1'b1;
        case (state_q)
            S_IDLE:  serOut = 1'b1;
            S_START: serOut = 1'b0;
            S_ADDR:  serOut = addr_q[bcnt_q[0]];
            S_LEN:   serOut = len_q[bcnt_q];
            S_DATA:  serOut = data_q[dcnt_q];
`ifdef SER_FRAME_TX_PARITY_EN
            S_PAR:   serOut = parity;
`endif
            S_STOP:  serOut = 1'b1;
            default: serOut = 1'b1;
        endcase
    end

    assign Done        = (state_q == S_IDLE);
    assign busy        = ~Done;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_ser_frame_tx.sv
// Self-checking bench for ser_frame_tx: directed frames plus randomized frames against a bit-queue model.
module tb_ser_frame_tx;

    logic        clk;
    logic        rst;
    logic        clkEn;
    logic        start;
    logic [1:0]  port_addr;
    logic [3:0]  data_len;
    logic [14:0] data_in;
    logic        serOut;
    logic        busy;
    logic        Done;
    logic [2:0]  state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    logic [0:0] exp_q[$];

    ser_frame_tx dut (
        .clk         (clk),
        .rst         (rst),
        .clkEn       (clkEn),
        .start       (start),
        .port_addr   (port_addr),
        .data_len    (data_len),
        .data_in     (data_in),
        .serOut      (serOut),
        .busy        (busy),
        .Done        (Done),
        .state_dbg_o (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic step(input logic en);
        clkEn = en;
        @(posedge clk);
        #1;
    endtask

    // Expected line bits of one frame, one entry per bit period, START through STOP.
    function automatic void model_frame(input logic [1:0] a, input logic [3:0] l, input logic [14:0] d);
        logic par;
        par = 1'b0;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 1; i >= 0; i--) begin exp_q.push_back(a[i]); par ^= a[i]; end
        for (int i = 3; i >= 0; i--) begin exp_q.push_back(l[i]); par ^= l[i]; end
        for (int i = int'(l) - 1; i >= 0; i--) begin exp_q.push_back(d[i]); par ^= d[i]; end
`ifdef SER_FRAME_TX_PARITY_EN
        exp_q.push_back(par);
`endif
        exp_q.push_back(1'b1);
    endfunction

    // Starts from IDLE, accepts the frame, then checks every cycle of it against exp_q.
    task automatic run_frame(input string tag, input logic [1:0] a, input logic [3:0] l,
                             input logic [14:0] d, input int period, input bit hold_start);
        port_addr = a;
        data_len  = l;
        data_in   = d;
        start     = 1'b1;
        for (int k = 0; k < period; k++) begin
            check_eq({tag, "/idle_ser"}, serOut, 1'b1);
            check_eq({tag, "/idle_done"}, Done, 1'b1);
            check_eq({tag, "/idle_busy"}, busy, 1'b0);
            step(k == period - 1);
        end
        if (!hold_start) start = 1'b0;
        for (int j = 0; j < exp_q.size(); j++) begin
            for (int k = 0; k < period; k++) begin
                check_eq({tag, "/ser"}, serOut, exp_q[j]);
                check_eq({tag, "/busy"}, busy, 1'b1);
                check_eq({tag, "/done"}, Done, 1'b0);
                port_addr = 2'($urandom);
                data_len  = 4'($urandom);
                data_in   = 15'($urandom);
                step(k == period - 1);
            end
        end
        check_eq({tag, "/end_done"}, Done, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        clkEn     = 1'b0;
        start     = 1'b0;
        port_addr = 2'd0;
        data_len  = 4'd0;
        data_in   = 15'd0;
        step(1'b0);
        step(1'b0);
        check_eq("reset/ser", serOut, 1'b1);
        check_eq("reset/busy", busy, 1'b0);
        check_eq("reset/done", Done, 1'b1);
        rst = 1'b0;
        step(1'b1);

        // Addr 10, L=3, payload 101.
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`ifdef SER_FRAME_TX_PARITY_EN
        exp_q.push_back(1'b1);
`endif
        exp_q.push_back(1'b1);
        run_frame("basic", 2'b10, 4'd3, 15'h0005, 1, 1'b0);
        run_frame("slow4", 2'b10, 4'd3, 15'h0005, 4, 1'b0);

        // Header-only frame.
        exp_q = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef SER_FRAME_TX_PARITY_EN
        exp_q.push_back(1'b1);
`endif
        exp_q.push_back(1'b1);
        run_frame("len0", 2'b01, 4'd0, 15'h7FFF, 1, 1'b0);

`ifdef SER_FRAME_TX_PARITY_EN
        exp_q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_frame("parity", 2'b11, 4'd1, 15'h0001, 1, 1'b0);
`endif

        // Start held high: frames follow each other with one idle period between them.
        model_frame(2'b11, 4'd15, 15'h7FFF);
        for (int n = 0; n < 3; n++) run_frame("b2b", 2'b11, 4'd15, 15'h7FFF, 1, 1'b1);
        start = 1'b0;
        step(1'b1);

        // Reset in the middle of DATA while clkEn is low, with start also high.
        port_addr = 2'b10;
        data_len  = 4'd8;
        data_in   = 15'h2AAA;
        start     = 1'b1;
        step(1'b1);
        start = 1'b0;
        for (int i = 0; i < 9; i++) step(1'b1);
        check_eq("mid/busy", busy, 1'b1);
        rst   = 1'b1;
        start = 1'b1;
        step(1'b0);
        check_eq("rst/ser", serOut, 1'b1);
        check_eq("rst/busy", busy, 1'b0);
        check_eq("rst/done", Done, 1'b1);
        step(1'b1);
        check_eq("rst_prio/done", Done, 1'b1);
        check_eq("rst_prio/ser", serOut, 1'b1);
        rst   = 1'b0;
        start = 1'b0;
        step(1'b1);
        model_frame(2'b01, 4'd5, 15'h0013);
        run_frame("after_rst", 2'b01, 4'd5, 15'h0013, 2, 1'b0);

        for (int n = 0; n < 24; n++) begin
            logic [1:0]  a;
            logic [3:0]  l;
            logic [14:0] d;
            int          per;
            bit          hold;
            a    = 2'($urandom_range(0, 3));
            l    = 4'($urandom_range(0, 15));
            d    = 15'($urandom);
            per  = int'($urandom_range(1, 3));
            hold = 1'($urandom_range(0, 1));
            model_frame(a, l, d);
            run_frame("rand", a, l, d, per, hold);
            if (!hold) begin
                for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                    step(1'($urandom_range(0, 1)));
                    check_eq("gap/done", Done, 1'b1);
                end
            end
        end
        start = 1'b0;
        step(1'b1);
        check_eq("final/done", Done, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
